// File: rtl/exu_types_pkg.sv
// Types and constants shared across the execute stage.
package exu_types_pkg;

    typedef enum logic [2:0] {
        DIV_NONE = 3'd0,
        DIV      = 3'd1,
        DIVU     = 3'd2,
        REM      = 3'd3,
        REMU     = 3'd4
    } riscv_div_op_e;

    localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_special_case.sv
// Resolves RISC-V divide corner cases (no-op, divide-by-zero, signed overflow)
// without the iterative divider.
module div_special_case
    import exu_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  riscv_div_op_e    op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             is_special,
    output logic [WIDTH-1:0] special_result
);

    localparam logic signed [WIDTH-1:0] S_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] S_NEG_ONE = '1;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    b_zero;
    logic                    ovf;

    assign a_s    = a;
    assign b_s    = b;
    assign b_zero = (b == '0);
    // Only the signed ops can overflow: most-negative / -1
    assign ovf    = (a_s == S_MIN) && (b_s == S_NEG_ONE);

    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        case (op)
            DIV, DIVU: begin
                if (b_zero) begin
                    is_special     = 1'b1;
                    special_result = '1;
                end else if (op == DIV && ovf) begin
                    is_special     = 1'b1;
                    special_result = a;
                end
            end
            REM, REMU: begin
                if (b_zero) begin
                    is_special     = 1'b1;
                    special_result = a;
                end else if (op == REM && ovf) begin
                    is_special     = 1'b1;
                    special_result = '0;
                end
            end
            default: begin
                is_special     = 1'b1;
                special_result = '0;
            end
        endcase
    end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider between two requesters;
// corner cases are answered locally without issuing to the divider.
module div_sched
    import exu_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  riscv_div_op_e    req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  riscv_div_op_e    req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             div_valid,
    input  logic             div_ready,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output riscv_div_op_e    div_op,

    input  logic             div_rsp_valid,
    output logic             div_rsp_ready,
    input  logic [WIDTH-1:0] div_rsp_result,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,

    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } div_sched_state_e;

    div_sched_state_e state;
    div_sched_state_e state_next;

    logic             last_grant;
    logic             owner;
    logic             grant;
    logic             req_fire;
    logic             issue_fire;
    logic             rsp_in_fire;
    logic             rsp_out_fire;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    riscv_div_op_e    sel_op;
    logic             is_special;
    logic [WIDTH-1:0] special_result;

    // On a tie the lane that did not win last time gets the grant
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready   = (state == S_IDLE) && req0_valid && !grant;
    assign req1_ready   = (state == S_IDLE) && req1_valid &&  grant;
    assign req_fire     = (state == S_IDLE) && (req0_valid || req1_valid);
    assign issue_fire   = div_valid && div_ready;
    assign rsp_in_fire  = div_rsp_valid && div_rsp_ready;
    assign rsp_out_fire = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;
    assign sel_op = grant ? req1_op : req0_op;

    div_special_case #(
        .WIDTH          (WIDTH)
    ) u_special (
        .op             (sel_op),
        .a              (sel_a),
        .b              (sel_b),
        .is_special     (is_special),
        .special_result (special_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req_fire)     state_next = is_special ? S_RESP : S_ISSUE;
            S_ISSUE: if (issue_fire)   state_next = S_WAIT;
            S_WAIT:  if (rsp_in_fire)  state_next = S_RESP;
            S_RESP:  if (rsp_out_fire) state_next = S_IDLE;
            default:                   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        div_valid     = (state == S_ISSUE);
        div_rsp_ready = (state == S_WAIT);
        rsp0_valid    = (state == S_RESP) && !owner;
        rsp1_valid    = (state == S_RESP) &&  owner;
        busy          = (state != S_IDLE);
    end

    // Accept boundary: capture the granted request; corner cases resolve here
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            div_op     <= DIV_NONE;
            rsp_result <= '0;
        end else if (req_fire) begin
            last_grant <= grant;
            owner      <= grant;
            div_a      <= sel_a;
            div_b      <= sel_b;
            div_op     <= sel_op;
            if (is_special) begin
                rsp_result <= special_result;
            end
        end else if (rsp_in_fire) begin
            rsp_result <= div_rsp_result;
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a reference divide model, a divider stand-in
// and a per-cycle response scoreboard.
module tb_div_sched;
    import exu_types_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    riscv_div_op_e req0_op, req1_op;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          div_valid, div_ready;
    logic [W-1:0]  div_a, div_b;
    riscv_div_op_e div_op;
    logic          div_rsp_valid, div_rsp_ready;
    logic [W-1:0]  div_rsp_result;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]  rsp_result;
    logic          busy;

    div_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .div_valid(div_valid), .div_ready(div_ready), .div_a(div_a), .div_b(div_b),
        .div_op(div_op),
        .div_rsp_valid(div_rsp_valid), .div_rsp_ready(div_rsp_ready),
        .div_rsp_result(div_rsp_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V divide semantics, full result for any operands
    function automatic logic [W-1:0] ref_div(input riscv_div_op_e op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == DIV_ALL_ONES);
        case (op)
            DIV:  if (b == 0) return DIV_ALL_ONES;
                  else if (ovf) return a;
                  else return W'($signed(a) / $signed(b));
            DIVU: if (b == 0) return DIV_ALL_ONES;
                  else return a / b;
            REM:  if (b == 0) return a;
                  else if (ovf) return '0;
                  else return W'($signed(a) % $signed(b));
            REMU: if (b == 0) return a;
                  else return a % b;
            default: return '0;
        endcase
    endfunction

    function automatic bit is_special_ref(input riscv_div_op_e op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        bit ovf;
        ovf = (a == 32'h8000_0000) && (b == DIV_ALL_ONES);
        return (op == DIV_NONE) || (b == 0) || ((op == DIV || op == REM) && ovf);
    endfunction

    typedef struct {
        int           lane;
        logic [W-1:0] res;
    } exp_t;

    exp_t         expq[$];
    int           acc_log[$];
    int           done_cnt  = 0;
    int           last_lane = -1;
    logic [W-1:0] last_res  = '0;

    // Scoreboard: accepts push the expected answer, responses are checked each valid cycle
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
        end else begin
            check("one_ready", W'(req0_ready && req1_ready), '0);
            if (req0_valid && req0_ready) begin
                expq.push_back('{0, ref_div(req0_op, req0_a, req0_b)});
                acc_log.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                expq.push_back('{1, ref_div(req1_op, req1_a, req1_b)});
                acc_log.push_back(1);
            end
            if (rsp0_valid || rsp1_valid) begin
                check("rsp_one_lane", W'(rsp0_valid && rsp1_valid), '0);
                check("rsp_pending", W'(expq.size() > 0), W'(1));
                if (expq.size() > 0) begin
                    check("rsp_lane", W'(rsp1_valid), W'(expq[0].lane));
                    check("rsp_result", rsp_result, expq[0].res);
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        last_lane = rsp1_valid ? 1 : 0;
                        last_res  = rsp_result;
                        void'(expq.pop_front());
                        done_cnt++;
                    end
                end
            end
        end
    end

    // Divider stand-in with programmable latency
    bit            dready_en = 1'b1;
    int            div_lat   = 2;
    int            div_fires = 0;
    bit            dv_rst, dv_issue, dv_rsp, dv_pend;
    int            dv_cnt;
    logic [W-1:0]  dv_a, dv_b, dv_res;
    riscv_div_op_e dv_op;

    initial begin
        div_ready      = 1'b0;
        div_rsp_valid  = 1'b0;
        div_rsp_result = '0;
        dv_pend        = 1'b0;
        dv_cnt         = 0;
        forever begin
            @(negedge clk);
            dv_rst   = rst;
            dv_issue = div_valid && div_ready;
            dv_rsp   = div_rsp_valid && div_rsp_ready;
            dv_a     = div_a;
            dv_b     = div_b;
            dv_op    = div_op;
            @(posedge clk);
            #1;
            if (dv_rst) begin
                dv_pend       = 1'b0;
                div_rsp_valid = 1'b0;
            end else begin
                if (dv_rsp) div_rsp_valid = 1'b0;
                if (dv_issue) begin
                    div_fires++;
                    check("div_not_special", W'(is_special_ref(dv_op, dv_a, dv_b)), '0);
                    dv_pend = 1'b1;
                    dv_cnt  = div_lat;
                    dv_res  = ref_div(dv_op, dv_a, dv_b);
                end
                if (dv_pend) begin
                    if (dv_cnt == 0) begin
                        div_rsp_valid  = 1'b1;
                        div_rsp_result = dv_res;
                        dv_pend        = 1'b0;
                    end else begin
                        dv_cnt--;
                    end
                end
            end
            div_ready = dready_en;
        end
    end

    task automatic drive_req(input int lane, input riscv_div_op_e op, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        if (lane == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic do_req(input int lane, input riscv_div_op_e op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input bit fast);
        int n0, f0;
        bit got;
        n0 = done_cnt;
        f0 = div_fires;
        check("model_pin", ref_div(op, a, b), exp);
        @(posedge clk); #1;
        drive_req(lane, op, a, b);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = (lane == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
        end
        check("accept", W'(got), W'(1));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        if (got) begin
            if (fast) begin
                check("fast_rsp_t1", W'((lane == 0) ? rsp0_valid : rsp1_valid), W'(1));
                check("fast_no_issue", W'(div_valid), '0);
            end else begin
                check("issue_t1", W'(div_valid), W'(1));
                if (dready_en) begin
                    @(negedge clk);
                    check("wait_t2", W'(div_rsp_ready), W'(1));
                end
            end
        end
        for (int i = 0; i < 300 && done_cnt == n0; i++) @(negedge clk);
        check("done", W'(done_cnt - n0), W'(1));
        check("rsp_lane_direct", W'(last_lane), W'(lane));
        check("rsp_value", last_res, exp);
        check("div_fires", W'(div_fires - f0), fast ? '0 : W'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, n0;
        bit seen;
        rst        = 1'b1;
        req0_valid = 1'b0; req0_op = DIV_NONE; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = DIV_NONE; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", W'(busy), '0);
        check("rst_div_valid", W'(div_valid), '0);
        check("rst_div_rsp_ready", W'(div_rsp_ready), '0);
        check("rst_rsp_valid", W'({rsp1_valid, rsp0_valid}), '0);
        check("rst_req_ready", W'({req1_ready, req0_ready}), '0);
        check("rst_rsp_result", rsp_result, '0);
        check("rst_div_a", div_a, '0);
        check("rst_div_b", div_b, '0);
        check("rst_div_op", W'(div_op), W'(DIV_NONE));

        // Both lanes requesting continuously: grants must alternate starting with lane 0
        @(posedge clk); #1;
        drive_req(0, DIV, 32'd1000, 32'd10);
        drive_req(1, DIVU, 32'd99, 32'd3);
        a0 = acc_log.size();
        for (int i = 0; i < 400 && acc_log.size() < a0 + 4; i++) @(negedge clk);
        check("alt_count", W'(acc_log.size() - a0), W'(4));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (a0 + i < acc_log.size())
                check($sformatf("alt_grant%0d", i), W'(acc_log[a0 + i]), W'(i % 2));
        end
        for (int i = 0; i < 300 && expq.size() != 0; i++) @(negedge clk);
        check("alt_drain", W'(expq.size()), '0);

        do_req(0, DIV,  32'd100,       32'd7,         32'd14,        1'b0);
        do_req(1, REMU, 32'd5,         32'd0,         32'd5,         1'b1);
        do_req(0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        do_req(0, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
        do_req(1, DIVU, 32'd7,         32'd0,         DIV_ALL_ONES,  1'b1);
        do_req(0, REM,  32'd9,         32'd0,         32'd9,         1'b1);
        do_req(1, DIV_NONE, 32'd3,     32'd4,         32'd0,         1'b1);
        do_req(1, DIV,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 1'b0);
        do_req(0, REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 1'b0);
        do_req(1, DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);

        // Requester 1 back-pressures its response for 10 cycles
        rsp1_ready = 1'b0;
        @(posedge clk); #1;
        drive_req(1, DIVU, 32'd50, 32'd5);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = req1_valid && req1_ready;
        end
        check("stall_accept", W'(seen), W'(1));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rsp1_valid;
        end
        check("stall_rsp_seen", W'(seen), W'(1));
        @(posedge clk); #1;
        drive_req(0, DIV, 32'd9, 32'd3);
        n0 = done_cnt;
        a0 = acc_log.size();
        repeat (10) begin
            @(negedge clk);
            check("stall_rsp1_valid", W'(rsp1_valid), W'(1));
            check("stall_rsp_result", rsp_result, 32'd10);
            check("stall_req_ready", W'({req1_ready, req0_ready}), '0);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 50 && acc_log.size() == a0; i++) @(negedge clk);
        check("resume_accept", W'(acc_log.size() - a0), W'(1));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 300 && done_cnt < n0 + 2; i++) @(negedge clk);
        check("resume_done", W'(done_cnt - n0), W'(2));
        check("resume_lane", W'(last_lane), '0);
        check("resume_value", last_res, 32'd3);

        // Reset while the divider owns the operation
        div_lat = 20;
        @(posedge clk); #1;
        drive_req(0, DIV, 32'd77, 32'd7);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = req0_valid && req0_ready;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = div_rsp_ready;
        end
        check("rst_wait_reached", W'(seen), W'(1));
        n0 = done_cnt;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", W'(busy), '0);
        check("mid_rst_div_rsp_ready", W'(div_rsp_ready), '0);
        check("mid_rst_rsp_valid", W'({rsp1_valid, rsp0_valid}), '0);
        check("mid_rst_div_valid", W'(div_valid), '0);
        div_lat = 2;
        repeat (25) @(negedge clk);
        check("mid_rst_no_rsp", W'(done_cnt - n0), '0);
        do_req(0, DIV, 32'd77, 32'd7, 32'd11, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
